// File: rtl/priority_encoder_pkg.sv
// priority_encoder_pkg: shared FSM state type and request/code widths.
package priority_encoder_pkg;
   localparam int N_REQ  = 4;
   localparam int CODE_W = 2;
   typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/priority_encoder_prio_enc4.sv
// prio_enc4: fixed-priority 4-to-2 encoder, in[3] highest; any flags a set bit.
module prio_enc4 (
   input  logic [3:0] in,
   output logic [1:0] idx,
   output logic       any
);
   always_comb begin
      idx = in[3] ? 2'd3 : in[2] ? 2'd2 : in[1] ? 2'd1 : 2'd0;
      any = |in;
   end
endmodule

// File: rtl/priority_encoder.sv
// priority_encoder: sticky request latch with fixed-priority grant and ack handshake.
module priority_encoder
   import priority_encoder_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_REQ-1:0]  req,
   input  logic              ack,
   output logic [CODE_W-1:0] code,
   output logic              valid,
   output logic [N_REQ-1:0]  pending
);
   state_t            state, state_nxt;
   logic [N_REQ-1:0]  clr, pending_nxt;
   logic [CODE_W-1:0] code_nxt, enc_idx;
   logic              enc_any;

   prio_enc4 u_enc (.in(pending), .idx(enc_idx), .any(enc_any));

   // a new req on the bit being acked re-sets it, so set wins over clear
   always_comb begin
      clr         = (state == GRANT && ack) ? N_REQ'(1) << code : '0;
      pending_nxt = (pending & ~clr) | req;
      state_nxt   = (state == IDLE) ? (enc_any ? GRANT : IDLE) : (ack ? IDLE : GRANT);
      code_nxt    = (state == IDLE && enc_any) ? enc_idx : code;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         valid   <= 1'b0;
         code    <= '0;
         pending <= '0;
      end else begin
         state   <= state_nxt;
         valid   <= state_nxt == GRANT;
         code    <= code_nxt;
         pending <= pending_nxt;
      end
   end
endmodule

// File: tb/tb_priority_encoder.sv
// tb_priority_encoder: directed steps with a queue of expected outputs per cycle.
module tb_priority_encoder;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic       ack;
   logic [1:0] code;
   logic       valid;
   logic [3:0] pending;

   typedef struct {
      logic       v;
      logic [1:0] c;
      logic [3:0] p;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad   = 0;
   int n     = 0;

   priority_encoder dut (
      .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
      .code(code), .valid(valid), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string t, input logic ev, input logic [1:0] ec, input logic [3:0] ep);
      total++;
      assert (valid === ev) else begin
         bad++;
         $error("FAIL %s valid: got %b expected %b", t, valid, ev);
      end
      total++;
      assert (code === ec) else begin
         bad++;
         $error("FAIL %s code: got %0d expected %0d", t, code, ec);
      end
      total++;
      assert (pending === ep) else begin
         bad++;
         $error("FAIL %s pending: got %b expected %b", t, pending, ep);
      end
   endtask

   task automatic step(input logic [3:0] r, input logic a, input logic ev, input logic [1:0] ec, input logic [3:0] ep);
      exp_t e;
      req = r;
      ack = a;
      sb.push_back('{v: ev, c: ec, p: ep});
      @(posedge clk);
      #1;
      n++;
      e = sb.pop_front();
      chk($sformatf("step%0d", n), e.v, e.c, e.p);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      req   = 4'b0000;
      ack   = 1'b0;
      #3;
      chk("reset", 1'b0, 2'd0, 4'b0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      // single-cycle request, two-cycle latency
      step(4'b0100, 0, 0, 2'd0, 4'b0100);
      step(4'b0000, 0, 1, 2'd2, 4'b0100);
      step(4'b0000, 1, 0, 2'd2, 4'b0000);
      step(4'b0000, 0, 0, 2'd2, 4'b0000);
      // three requests drained in priority order
      step(4'b1011, 0, 0, 2'd2, 4'b1011);
      step(4'b0000, 0, 1, 2'd3, 4'b1011);
      step(4'b0000, 1, 0, 2'd3, 4'b0011);
      step(4'b0000, 0, 1, 2'd1, 4'b0011);
      step(4'b0000, 1, 0, 2'd1, 4'b0001);
      step(4'b0000, 0, 1, 2'd0, 4'b0001);
      step(4'b0000, 1, 0, 2'd0, 4'b0000);
      step(4'b0000, 0, 0, 2'd0, 4'b0000);
      // higher-priority arrival does not preempt a grant
      step(4'b0010, 0, 0, 2'd0, 4'b0010);
      step(4'b0000, 0, 1, 2'd1, 4'b0010);
      step(4'b1000, 0, 1, 2'd1, 4'b1010);
      step(4'b1000, 0, 1, 2'd1, 4'b1010);
      step(4'b0000, 1, 0, 2'd1, 4'b1000);
      step(4'b0000, 0, 1, 2'd3, 4'b1000);
      step(4'b0000, 1, 0, 2'd3, 4'b0000);
      step(4'b0000, 0, 0, 2'd3, 4'b0000);
      // set wins over ack-clear on the same bit
      step(4'b0100, 0, 0, 2'd3, 4'b0100);
      step(4'b0000, 0, 1, 2'd2, 4'b0100);
      step(4'b0100, 1, 0, 2'd2, 4'b0100);
      step(4'b0000, 0, 1, 2'd2, 4'b0100);
      step(4'b0000, 1, 0, 2'd2, 4'b0000);
      step(4'b0000, 0, 0, 2'd2, 4'b0000);
      // ack while idle is ignored
      step(4'b0000, 1, 0, 2'd2, 4'b0000);
      step(4'b0000, 1, 0, 2'd2, 4'b0000);
      step(4'b0000, 1, 0, 2'd2, 4'b0000);
      // asynchronous reset mid-grant
      step(4'b0110, 0, 0, 2'd2, 4'b0110);
      step(4'b0000, 0, 1, 2'd2, 4'b0110);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset", 1'b0, 2'd0, 4'b0000);
      req = 4'b1111;
      @(posedge clk);
      #1;
      chk("reset_hold", 1'b0, 2'd0, 4'b0000);
      req   = 4'b0000;
      rst_n = 1'b1;
      step(4'b0000, 0, 0, 2'd0, 4'b0000);
      step(4'b0000, 0, 0, 2'd0, 4'b0000);
      step(4'b0001, 0, 0, 2'd0, 4'b0001);
      step(4'b0000, 0, 1, 2'd0, 4'b0001);
      step(4'b0000, 1, 0, 2'd0, 4'b0000);
      total++;
      assert (sb.size() == 0) else begin
         bad++;
         $error("FAIL scoreboard: got %0d left expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/priority_encoder.md
PRIORITY_ENCODER -- requirements
Module: priority_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port req  input  4  request lines; bit i requests code i; sampled each rising edge.
REQ-005 Port ack  input  1  consumer accepts the presented code; meaningful only while valid=1.
REQ-006 Port code  output  2  binary index of the granted request; registered.
REQ-007 Port valid  output  1  code holds a granted request; registered.
REQ-008 Port pending  output  4  sticky latched requests not yet acknowledged; registered.

Function
REQ-009 Priority SHALL be fixed: req[3] highest, req[0] lowest; code = index of the highest set bit of pending.
REQ-010 pending SHALL update each edge: pending <= (pending & ~clr) | req, where clr = one-hot(code) when valid&ack, else 0.
REQ-011 When the same bit is set by req and cleared by ack in one cycle, set SHALL win and the bit SHALL stay pending.
REQ-012 The FSM SHALL have two states: IDLE (valid=0) and GRANT (valid=1).
REQ-013 IDLE -> GRANT when registered pending != 0; code is loaded with the priority index of pending on that edge.
REQ-014 IDLE SHALL be held while pending == 0; code then retains its last value.
REQ-015 GRANT SHALL hold while ack=0; code SHALL stay stable even if a higher-priority request arrives.
REQ-016 GRANT -> IDLE on ack=1; the granted bit is cleared on the same edge.
REQ-017 After each ack the block SHALL spend exactly one cycle in IDLE before the next grant.
REQ-018 Latency SHALL be 2 cycles: req bit high before edge N sets pending after edge N and valid after edge N+1 (from IDLE with pending=0).
REQ-019 Throughput SHALL be at most one grant per 2 cycles when ack is returned in the first GRANT cycle.
REQ-020 ack while valid=0 SHALL be ignored; it clears nothing.
REQ-021 A req pulse of one cycle SHALL be remembered in pending until granted and acknowledged.
REQ-022 Repeated req on an already pending bit SHALL have no further effect; no request counting.

Reset
REQ-023 While rst_n=0: pending=4'b0000, code=2'b00, valid=0, FSM=IDLE, independent of clk.
REQ-024 Reset asserted mid-GRANT SHALL drop valid immediately and discard all pending requests.
REQ-025 After rst_n deasserts, req SHALL first be sampled on the next rising edge.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, GRANT) and the constants N_REQ=4 and CODE_W=2.
REQ-027 The combinational 4-to-2 priority function SHALL be a sub-module named prio_enc4, with inputs in[3:0] and outputs idx[1:0] and any.
REQ-028 All outputs SHALL come directly from registers; no combinational path from req or ack to any output.

Verification
REQ-029 Reset release, req=4'b0100 for one cycle -> pending=4'b0100 after edge 1, valid=1 and code=2 after edge 2.
REQ-030 req=4'b1011 in one cycle, ack on each grant -> codes 3, 1, 0 in order, one IDLE cycle between grants, pending ends at 0000.
REQ-031 In GRANT with code=1 and ack=0, pulse req=4'b1000 -> code stays 1 until ack; the next grant is code 3.
REQ-032 In GRANT with code=2, ack=1 and req=4'b0100 in the same cycle -> pending[2] stays 1; code 2 is granted again after one IDLE cycle.
REQ-033 In IDLE with pending=0, ack=1 for 3 cycles -> valid and pending stay 0.
REQ-034 In GRANT with pending=4'b0110, assert rst_n=0 between edges -> valid=0 and pending=0000 without a clock edge; no grant after release until a new req.
